// File: rtl/rv32_defs_pkg.sv
// Shared RV32 definitions: opcodes, immediate-format selects, NOP and fetch state encoding.
package rv32_defs;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned OPC_W     = 7;
  localparam int unsigned IMM_SEL_W = 2;

  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;

  localparam logic [IMM_SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [IMM_SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [IMM_SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [IMM_SEL_W-1:0] IMM_U = 2'b11;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    FETCH_REQ  = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      inst;
    logic [XLEN-1:0]      pc;
    logic [IMM_SEL_W-1:0] imm_sel;
  } fetch_out_t;

endpackage

// File: rtl/imm_sel_decode.sv
// Opcode to immediate-format select; J-type falls through to I since the
// extender never builds J immediates.
module imm_sel_decode
  import rv32_defs::*;
(
  input  logic [OPC_W-1:0]     opcode,
  output logic [IMM_SEL_W-1:0] sel_c
);

  always_comb begin
    sel_c = IMM_I;
    case (opcode)
      OP_STORE:          sel_c = IMM_S;
      OP_BRANCH:         sel_c = IMM_B;
      OP_LUI, OP_AUIPC:  sel_c = IMM_U;
      default:           sel_c = IMM_I;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction fetch: single outstanding imem request, output instruction
// register with opcode pre-decode, and execute-driven redirects.
module fetch_stage
  import rv32_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [XLEN-1:0]      imem_addr,
  input  logic                 imem_rsp_valid,
  input  logic [XLEN-1:0]      imem_rsp_data,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [XLEN-1:0]      inst,
  output logic [XLEN-1:0]      inst_pc,
  output logic [IMM_SEL_W-1:0] inst_imm_sel
);

  fetch_state_e         state_q, state_d;
  logic [XLEN-1:0]      pc_q, pc_d;
  logic                 kill_q, kill_d;
  fetch_out_t           out_q, out_d;
  logic [IMM_SEL_W-1:0] rsp_sel_c;
  logic                 unused_redirect_lsb;

  imm_sel_decode u_imm_sel_decode (
    .opcode (imem_rsp_data[OPC_W-1:0]),
    .sel_c  (rsp_sel_c)
  );

  // Only request when the output slot is certain to be free on response.
  assign imem_req_valid = (state_q == FETCH_REQ) && (!out_q.valid || inst_ready)
                          && !redirect_valid;
  assign imem_addr      = pc_q;
  assign inst_valid     = out_q.valid;
  assign inst           = out_q.inst;
  assign inst_pc        = out_q.pc;
  assign inst_imm_sel   = out_q.imm_sel;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    out_d   = out_q;

    if (out_q.valid && inst_ready) begin
      out_d.valid = 1'b0;
    end

    if (redirect_valid) begin
      pc_d        = {redirect_pc[XLEN-1:2], 2'b00};
      out_d.valid = 1'b0;
      if (state_q == FETCH_WAIT) begin
        if (imem_rsp_valid) begin
          kill_d  = 1'b0;
          state_d = FETCH_REQ;
        end else begin
          kill_d  = 1'b1;
        end
      end
    end else begin
      case (state_q)
        FETCH_REQ: begin
          if (imem_req_valid && imem_req_ready) begin
            state_d = FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (imem_rsp_valid) begin
            state_d = FETCH_REQ;
            if (kill_q) begin
              kill_d = 1'b0;
            end else begin
              out_d.valid   = 1'b1;
              out_d.inst    = imem_rsp_data;
              out_d.pc      = pc_q;
              out_d.imm_sel = rsp_sel_c;
              pc_d          = pc_q + XLEN'(4);
            end
          end
        end
        default: state_d = FETCH_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FETCH_REQ;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      out_q.valid   <= 1'b0;
      out_q.inst    <= NOP;
      out_q.pc      <= RESET_PC;
      out_q.imm_sel <= IMM_I;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic checked
// against a transaction-level model of the fetch pipeline.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [1:0]  inst_imm_sel;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_imm_sel   (inst_imm_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  // Reference model: next fetch address, one pending request, held instruction.
  logic [31:0] m_pc, m_inst, m_ipc, pend_addr;
  bit          m_valid, pend, stale;
  int unsigned delay;

  // Stimulus knobs.
  int unsigned p_req_rdy, p_inst_rdy, p_redir, min_delay, max_delay;
  bit          force_redir, spur_rsp;
  logic [31:0] force_tgt;
  logic [31:0] data_q[$];

  function automatic logic [1:0] ref_sel(input logic [31:0] w);
    case (w[6:0])
      7'h23:        return 2'd1;
      7'h63:        return 2'd2;
      7'h37, 7'h17: return 2'd3;
      default:      return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] random_word();
    logic [6:0]  ops [6] = '{7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h13};
    logic [31:0] w;
    w      = $urandom;
    w[6:0] = ops[$urandom_range(5)];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_inst = 32'h0000_0013;
    m_valid = 0; pend = 0; stale = 0; delay = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_imm_sel", inst_imm_sel, 0);
    chk("rst_req_valid", imem_req_valid, 1);
    chk("rst_imem_addr", imem_addr, 32'h0);
    rst_n = 1'b1;
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic step();
    bit          rsp_real, exp_req, accepted;
    logic [31:0] data;
    chk("inst_valid", inst_valid, m_valid);
    if (m_valid) begin
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_ipc);
      chk("inst_imm_sel", inst_imm_sel, ref_sel(m_inst));
    end
    redirect_valid = force_redir || ($urandom_range(99) < p_redir);
    redirect_pc    = force_redir ? force_tgt : $urandom;
    inst_ready     = $urandom_range(99) < p_inst_rdy;
    imem_req_ready = $urandom_range(99) < p_req_rdy;
    rsp_real       = pend && (delay == 0);
    if (rsp_real) data = (data_q.size() > 0) ? data_q.pop_front() : random_word();
    else          data = $urandom;
    imem_rsp_valid = rsp_real || (spur_rsp && !pend);
    imem_rsp_data  = data;
    force_redir = 0;
    spur_rsp    = 0;
    #1;
    exp_req = !pend && (!m_valid || inst_ready) && !redirect_valid;
    chk("req_valid", imem_req_valid, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);

    accepted = 0;
    if (pend && !rsp_real && delay > 0) delay--;
    if (m_valid && inst_ready) begin
      m_valid = 0;
      if (!redirect_valid) delivered++;
    end
    if (redirect_valid) begin
      m_pc    = redirect_pc & 32'hFFFF_FFFC;
      m_valid = 0;
      if (pend) begin
        if (rsp_real) pend = 0;
        else          stale = 1;
      end
    end else if (pend && rsp_real) begin
      pend = 0;
      if (!stale) begin
        m_valid = 1; m_inst = data; m_ipc = pend_addr; m_pc = pend_addr + 32'd4;
      end
      stale = 0;
    end else if (exp_req && imem_req_ready) begin
      accepted = 1;
      pend = 1; stale = 0; pend_addr = m_pc;
      delay = $urandom_range(max_delay, min_delay);
    end
    if (accepted) chk("accept_addr", imem_addr, pend_addr);
    @(negedge clk);
  endtask

  task automatic knobs(input int unsigned rq, input int unsigned ir, input int unsigned rd,
                       input int unsigned dmin, input int unsigned dmax);
    p_req_rdy = rq; p_inst_rdy = ir; p_redir = rd; min_delay = dmin; max_delay = dmax;
  endtask

  initial begin
    force_redir = 0; spur_rsp = 0; force_tgt = 32'h0;
    knobs(100, 100, 0, 0, 0);
    do_reset();

    // Basic fetch with one-cycle response latency.
    data_q.push_back(32'h00500093);
    repeat (4) step();

    // Memory back-pressure for three cycles.
    knobs(0, 100, 0, 0, 0);
    repeat (3) step();
    knobs(100, 100, 0, 0, 0);
    repeat (4) step();

    // Downstream stall holds the instruction and blocks new requests.
    knobs(100, 0, 0, 0, 0);
    repeat (5) step();
    knobs(100, 100, 0, 0, 0);
    repeat (3) step();

    // Redirect during WAIT with the response two cycles later.
    knobs(100, 100, 0, 2, 2);
    for (int i = 0; i < 10 && !pend; i++) step();
    force_redir = 1; force_tgt = 32'h0000_0103;
    repeat (6) step();

    // Redirect coinciding with the response.
    knobs(100, 100, 0, 0, 0);
    for (int i = 0; i < 10 && !pend; i++) step();
    force_redir = 1; force_tgt = 32'h0000_0200;
    repeat (4) step();

    // Immediate-format select for S, B, U and J words.
    data_q.push_back(32'h00112023);
    data_q.push_back(32'hFE000EE3);
    data_q.push_back(32'h123450B7);
    data_q.push_back(32'h0000006F);
    repeat (10) step();

    // Reset with a request outstanding; the late response must be ignored.
    knobs(100, 100, 0, 3, 3);
    for (int i = 0; i < 10 && !pend; i++) step();
    do_reset();
    knobs(0, 100, 0, 0, 0);
    spur_rsp = 1;
    repeat (3) step();

    // Randomized traffic.
    knobs(70, 70, 5, 0, 3);
    repeat (3000) step();
    knobs(100, 100, 0, 0, 0);
    repeat (10) step();

    chk("delivered_any", 32'(delivered > 50), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage for the RV32 core. It owns the PC, issues one word request at a time to instruction memory, and captures the returned word in an output instruction register. The held instruction feeds the decoder and the immediate extender. The block pre-decodes the opcode into the 2-bit immediate-format select used by the immediate extender, and honours branch/jump redirects from execute.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
imem_req_valid  out  1  request valid to instruction memory
imem_req_ready  in  1  memory accepts request this cycle
imem_addr  out  32  word address of request; always equals the PC register
imem_rsp_valid  in  1  response data valid; earliest one cycle after acceptance
imem_rsp_data  in  32  returned instruction word
redirect_valid  in  1  execute requests a PC change
redirect_pc  in  32  redirect target; bits [1:0] ignored
inst_valid  out  1  instruction register holds a valid instruction
inst_ready  in  1  downstream consumes the instruction this cycle
inst  out  32  held instruction word
inst_pc  out  32  PC of the held instruction
inst_imm_sel  out  2  immediate-format select: 00 I/R, 01 S, 10 B, 11 U

Behaviour:
- State: pc[31:0], state in {REQ, WAIT}, kill flag, output register {inst_valid, inst, inst_pc, inst_imm_sel}.
- Reset (rst_n=0 at a clock edge) gives pc=RESET_PC, state=REQ, kill=0, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC, inst_imm_sel=00.
- Reset mid-transaction discards any outstanding request. A response arriving after reset is ignored, because state is REQ.
- Output transfer occurs when inst_valid && inst_ready. inst_valid clears on transfer unless it is reloaded in the same cycle.
- imem_req_valid = (state==REQ) && (!inst_valid || inst_ready) && !redirect_valid.
  - A request is only issued if the output slot is guaranteed free when the response lands.
  - imem_addr is combinational from pc and is stable while imem_req_valid && !imem_req_ready.
- REQ: on imem_req_valid && imem_req_ready, go to WAIT.
- WAIT with imem_rsp_valid && !kill && !redirect_valid:
  - inst <= imem_rsp_data; inst_pc <= pc; inst_valid <= 1; inst_imm_sel <= decoded select.
  - pc <= pc + 4, wrapping modulo 2^32.
  - Go to REQ.
- Single outstanding request; peak throughput is one instruction per 2 cycles.
- WAIT with imem_rsp_valid && kill: drop the data, kill <= 0, go to REQ.
- Redirect (redirect_valid=1) has priority over everything except reset:
  - pc <= {redirect_pc[31:2], 2'b00}; inst_valid <= 0. The held instruction is flushed and no transfer is counted that cycle.
  - In REQ: no request is issued that cycle; stay in REQ.
  - In WAIT with no response this cycle: kill <= 1; stay in WAIT.
  - In WAIT with a response this cycle: drop the response; kill <= 0; go to REQ.
- Immediate select is decoded from opcode inst[6:0]:
  - 0100011 gives 01.
  - 1100011 gives 10.
  - 0110111 and 0010111 give 11.
  - All others give 00, including JAL; J-type immediates are handled outside the immediate extender.

Decomposition:
- Shared package rv32_defs holds:
  - opcode constants (OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC);
  - immediate-select encodings IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_U=2'b11;
  - NOP constant 32'h0000_0013;
  - fetch state encoding.
- One natural sub-module: imm_sel_decode, a combinational opcode[6:0] to sel[1:0] mapping reusable by the decoder.

Test Plan:
- Reset, then req_ready=1, rsp one cycle later with 32'h00500093: imem_addr=0 in cycle 1; inst_valid=1, inst=32'h00500093, inst_pc=0, inst_imm_sel=00; next request at addr 4.
- req_ready held 0 for 3 cycles: imem_req_valid stays 1 and imem_addr stays constant; accepted on cycle 4; no duplicate request.
- inst_ready=0 with inst_valid=1: no new imem_req_valid; inst and inst_pc unchanged for 5 cycles; after inst_ready=1, the next request issues the same cycle.
- Redirect to 32'h0000_0103 during WAIT, response 2 cycles later: response dropped, inst_valid stays 0; next request addr=32'h0000_0100.
- Redirect in the same cycle as the response: response discarded; next imem_addr equals the target; inst_valid=0.
- Fetch 32'h00112023, 32'hFE000EE3, 32'h123450B7, 32'h0000006F in sequence: inst_imm_sel = 01, 10, 11, 00 respectively.
